// File: rtl/btn_irq_ctrl_if.sv
// IPIF slave bus bundle between the bus attachment and btn_irq_ctrl.
// The master modport is the bus side and the slave modport is the peripheral side.
interface btn_irq_ctrl_if #(
    parameter int DW = 32,
    parameter int NR = 4
);
    logic [DW-1:0]   Bus2IP_Data;
    logic [DW/8-1:0] Bus2IP_BE;
    logic [NR-1:0]   Bus2IP_RdCE;
    logic [NR-1:0]   Bus2IP_WrCE;
    logic [DW-1:0]   IP2Bus_Data;
    logic            IP2Bus_RdAck;
    logic            IP2Bus_WrAck;
    logic            IP2Bus_Error;

    modport master (
        output Bus2IP_Data,
        output Bus2IP_BE,
        output Bus2IP_RdCE,
        output Bus2IP_WrCE,
        input  IP2Bus_Data,
        input  IP2Bus_RdAck,
        input  IP2Bus_WrAck,
        input  IP2Bus_Error
    );

    modport slave (
        input  Bus2IP_Data,
        input  Bus2IP_BE,
        input  Bus2IP_RdCE,
        input  Bus2IP_WrCE,
        output IP2Bus_Data,
        output IP2Bus_RdAck,
        output IP2Bus_WrAck,
        output IP2Bus_Error
    );
endinterface

// File: rtl/btn_irq_ctrl.sv
// Push-button peripheral: synchroniser, debouncer, edge latch (W1C ISR) and level irq.
// Define BTN_GIE_EN to make IER[31] a global interrupt enable.
module btn_irq_ctrl #(
    parameter int C_SLV_DWIDTH      = 32,
    parameter int C_NUM_REG         = 4,
    parameter int C_NUM_BTN         = 3,
    parameter int C_DEBOUNCE_CYCLES = 250000,
    parameter int C_SYNC_STAGES     = 2
) (
    input  logic                 Bus2IP_Clk,
    input  logic                 Bus2IP_Reset,
    btn_irq_ctrl_if.slave        bus,
    input  logic [C_NUM_BTN-1:0] btn,
    output logic                 irq
);

    localparam int CW = $clog2(C_DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_DEBOUNCE_CYCLES - 1);
    localparam int NB = C_NUM_BTN;

    logic [C_SYNC_STAGES-1:0][NB-1:0] sync_q;
    logic [NB-1:0] s;
    logic [CW-1:0] cnt_q [NB];
    logic [NB-1:0] stable_q;
    logic [NB-1:0] evt_q;

    logic [NB-1:0] ier_q;
    logic [NB-1:0] isr_q;
    logic [NB-1:0] edge_q;
    logic          gie;

    logic [C_SLV_DWIDTH-1:0] wmask;
    logic [NB-1:0]           wd;
    logic [NB-1:0]           wm;
    logic [NB-1:0]           isr_clr;
    logic [C_SLV_DWIDTH-1:0] ier_rd;
    logic [C_SLV_DWIDTH-1:0] rdata;
    logic                    unused_bits;

    always_comb begin
        wmask = '0;
        for (int k = 0; k < C_SLV_DWIDTH / 8; k++) begin
            wmask[8*k +: 8] = {8{bus.Bus2IP_BE[k]}};
        end
    end

    assign wd = bus.Bus2IP_Data[NB-1:0];
    assign wm = wmask[NB-1:0];
    assign unused_bits = &{1'b0, bus.Bus2IP_Data[C_SLV_DWIDTH-1:NB],
                           wmask[C_SLV_DWIDTH-1:NB]};

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int i = 1; i < C_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[C_SYNC_STAGES-1];

    // evt_q marks an accepted level change, so ISR sets one clock after STATE
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            evt_q    <= '0;
        end else begin
            evt_q <= '0;
            for (int i = 0; i < NB; i++) begin
                if (s[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i]    <= '0;
                    stable_q[i] <= s[i];
                    evt_q[i]    <= s[i] | edge_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign isr_clr = bus.Bus2IP_WrCE[1] ? (wd & wm) : '0;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            ier_q  <= '0;
            isr_q  <= '0;
            edge_q <= '0;
        end else begin
            if (bus.Bus2IP_WrCE[0]) begin
                ier_q <= (ier_q & ~wm) | (wd & wm);
            end
            if (bus.Bus2IP_WrCE[3]) begin
                edge_q <= (edge_q & ~wm) | (wd & wm);
            end
            isr_q <= (isr_q & ~isr_clr) | evt_q;
        end
    end

`ifdef BTN_GIE_EN
    logic gie_q;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            gie_q <= 1'b0;
        end else if (bus.Bus2IP_WrCE[0] && bus.Bus2IP_BE[C_SLV_DWIDTH/8-1]) begin
            gie_q <= bus.Bus2IP_Data[C_SLV_DWIDTH-1];
        end
    end

    assign gie = gie_q;
`else
    assign gie = 1'b1;
`endif

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            irq <= 1'b0;
        end else begin
            irq <= gie & (|(isr_q & ier_q));
        end
    end

`ifdef BTN_GIE_EN
    assign ier_rd = C_SLV_DWIDTH'(ier_q) | {gie, {(C_SLV_DWIDTH-1){1'b0}}};
`else
    assign ier_rd = C_SLV_DWIDTH'(ier_q);
`endif

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            bus.Bus2IP_RdCE[0]: rdata = ier_rd;
            bus.Bus2IP_RdCE[1]: rdata = C_SLV_DWIDTH'(isr_q);
            bus.Bus2IP_RdCE[2]: rdata = C_SLV_DWIDTH'(stable_q);
            bus.Bus2IP_RdCE[3]: rdata = C_SLV_DWIDTH'(edge_q);
            default:            rdata = '0;
        endcase
    end

    assign bus.IP2Bus_Data  = rdata;
    assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
    assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
    assign bus.IP2Bus_Error = bus.Bus2IP_WrCE[2];

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Self-checking bench for btn_irq_ctrl (3 buttons, 16-cycle debounce).
// Expected values go into a scoreboard queue and are popped as the DUT answers.
module tb_btn_irq_ctrl;

    localparam int NB = 3;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = '0;
    logic          irq;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] sbq [$];

    always #10 clk = ~clk;

    btn_irq_ctrl_if bus ();

    btn_irq_ctrl #(
        .C_NUM_BTN(NB),
        .C_DEBOUNCE_CYCLES(DB)
    ) dut (
        .Bus2IP_Clk(clk),
        .Bus2IP_Reset(rst),
        .bus(bus),
        .btn(btn),
        .irq(irq)
    );

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rd(input int r, output logic [31:0] d, output logic ack);
        @(posedge clk);
        #1 bus.Bus2IP_RdCE = 4'(1 << r);
        #2;
        d   = bus.IP2Bus_Data;
        ack = bus.IP2Bus_RdAck;
        @(posedge clk);
        #1 bus.Bus2IP_RdCE = '0;
    endtask

    task automatic wr(input int r, input logic [31:0] d, input logic [3:0] be,
                      output logic ack, output logic err);
        @(posedge clk);
        #1;
        bus.Bus2IP_WrCE = 4'(1 << r);
        bus.Bus2IP_Data = d;
        bus.Bus2IP_BE   = be;
        #2;
        ack = bus.IP2Bus_WrAck;
        err = bus.IP2Bus_Error;
        @(posedge clk);
        #1;
        bus.Bus2IP_WrCE = '0;
        bus.Bus2IP_Data = '0;
        bus.Bus2IP_BE   = '0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        logic a;
        btn = '0;
        do_reset();
        #2;
        n_run++;
        if (irq !== 1'b0 || bus.IP2Bus_RdAck !== 1'b0 ||
            bus.IP2Bus_WrAck !== 1'b0 || bus.IP2Bus_Data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle: irq=%b rdack=%b wrack=%b data=%h want 0 0 0 0",
                     irq, bus.IP2Bus_RdAck, bus.IP2Bus_WrAck, bus.IP2Bus_Data);
        end
        for (int r = 0; r < 4; r++) sbq.push_back(32'h0);
        for (int r = 0; r < 4; r++) begin
            rd(r, d, a);
            e = sbq.pop_front();
            n_run++;
            if (d !== e || a !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h ack %b want %h ack 1", r, d, a, e);
            end
        end
        #1;
        n_run++;
        if (bus.IP2Bus_RdAck !== 1'b0) begin
            n_fail++;
            $display("FAIL rdack_drop: got %b want 0", bus.IP2Bus_RdAck);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d, e;
        logic a, er;
        int first_state, first_irq;
        do_reset();
        wr(0, 32'h7, 4'hf, a, er);
        btn = 3'b001;
        sbq.push_back(32'd18);
        sbq.push_back(32'd20);
        sbq.push_back(32'h1);
        first_state = 0;
        first_irq   = 0;
        bus.Bus2IP_RdCE = 4'b0100;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk);
            #1;
            if (first_state == 0 && bus.IP2Bus_Data == 32'h1) first_state = i;
            if (first_irq == 0 && irq === 1'b1) first_irq = i;
        end
        bus.Bus2IP_RdCE = '0;
        e = sbq.pop_front();
        n_run++;
        if (32'(first_state) !== e) begin
            n_fail++;
            $display("FAIL state_latency: got %0d want %0d", first_state, e);
        end
        e = sbq.pop_front();
        n_run++;
        if (32'(first_irq) !== e) begin
            n_fail++;
            $display("FAIL irq_latency: got %0d want %0d", first_irq, e);
        end
        rd(1, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL isr_after_press: got %h want %h", d, e);
        end
        wr(0, 32'h0, 4'hf, a, er);
        wait_cyc(1);
        n_run++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_masked: got %b want 0", irq);
        end
        btn = '0;
    endtask

    task automatic test_bounce();
        logic [31:0] d, e;
        logic a, er;
        logic [2:0] j;
        int bad;
        btn = '0;
        do_reset();
        wr(0, 32'h7, 4'hf, a, er);
        wr(3, 32'h7, 4'hf, a, er);
        j   = 3'b000;
        bad = 0;
        bus.Bus2IP_RdCE = 4'b0100;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            j   = {j[1:0], ~j[2]};
            btn = j;
            #1;
            if (bus.IP2Bus_Data !== 32'h0 || irq !== 1'b0) bad++;
        end
        bus.Bus2IP_RdCE = '0;
        btn = '0;
        n_run++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bounce_quiet: got %0d bad cycles want 0", bad);
        end
        sbq.push_back(32'h0);
        rd(1, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL bounce_isr: got %h want %h", d, e);
        end
    endtask

    task automatic test_edge();
        logic [31:0] d, e;
        logic a, er;
        logic [2:0] pat [4];
        logic [3:0] emode;
        pat   = '{3'b010, 3'b000, 3'b010, 3'b000};
        emode = 4'b0011;
        do_reset();
        sbq.push_back(32'h2);
        sbq.push_back(32'h2);
        sbq.push_back(32'h2);
        sbq.push_back(32'h0);
        for (int k = 0; k < 4; k++) begin
            wr(3, emode[k] ? 32'h2 : 32'h0, 4'hf, a, er);
            btn = pat[k];
            wait_cyc(22);
            rd(1, d, a);
            e = sbq.pop_front();
            n_run++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL edge_step%0d: got %h want %h", k, d, e);
            end
            wr(1, 32'h7, 4'hf, a, er);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] d, e;
        logic a, er;
        do_reset();
        wr(3, 32'h1, 4'hf, a, er);
        btn = 3'b101;
        sbq.push_back(32'h5);
        sbq.push_back(32'h1);
        sbq.push_back(32'h1);
        sbq.push_back(32'h0);
        wait_cyc(22);
        rd(1, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL w1c_set: got %h want %h", d, e);
        end
        wr(1, 32'h4, 4'hf, a, er);
        rd(1, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL w1c_clear: got %h want %h", d, e);
        end
        // release bit 0 so its event lands on the same edge as the clear
        btn = 3'b100;
        repeat (17) @(posedge clk);
        wr(1, 32'h1, 4'hf, a, er);
        rd(1, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL set_wins: got %h want %h", d, e);
        end
        wr(1, 32'h1, 4'hf, a, er);
        rd(1, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL w1c_final: got %h want %h", d, e);
        end
        btn = '0;
    endtask

    task automatic test_be_err();
        logic [31:0] d, e;
        logic a, er;
        do_reset();
        sbq.push_back(32'h5);
        sbq.push_back(32'h5);
        sbq.push_back(32'h2);
        sbq.push_back(32'h7);
        sbq.push_back(32'h0);
        wr(0, 32'h5, 4'hf, a, er);
        n_run++;
        if (a !== 1'b1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL ier_ack: got ack %b err %b want 1 0", a, er);
        end
        wr(0, 32'h2, 4'h0, a, er);
        rd(0, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL be_none: got %h want %h", d, e);
        end
        wr(0, 32'h0, 4'b1110, a, er);
        rd(0, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL be_upper: got %h want %h", d, e);
        end
        wr(0, 32'h2, 4'b0001, a, er);
        rd(0, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL be_byte0: got %h want %h", d, e);
        end
        wr(0, 32'h7fff_ffff, 4'hf, a, er);
        rd(0, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL ier_width: got %h want %h", d, e);
        end
        wr(2, 32'hffff_ffff, 4'hf, a, er);
        n_run++;
        if (a !== 1'b1 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL state_err: got ack %b err %b want 1 1", a, er);
        end
        rd(2, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL state_ro: got %h want %h", d, e);
        end
    endtask

    task automatic test_gie();
        logic [31:0] d, e;
        logic a, er;
        do_reset();
        btn = 3'b001;
        wait_cyc(22);
        wr(0, 32'h1, 4'hf, a, er);
        wait_cyc(1);
`ifdef BTN_GIE_EN
        sbq.push_back(32'h8000_0001);
        n_run++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL gie_off: got irq %b want 0", irq);
        end
        wr(0, 32'h8000_0001, 4'hf, a, er);
        n_run++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL gie_lag: got irq %b want 0", irq);
        end
        wait_cyc(1);
        n_run++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL gie_on: got irq %b want 1", irq);
        end
`else
        sbq.push_back(32'h1);
        n_run++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_on: got irq %b want 1", irq);
        end
        wr(0, 32'h8000_0001, 4'hf, a, er);
`endif
        rd(0, d, a);
        e = sbq.pop_front();
        n_run++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL ier_bit31: got %h want %h", d, e);
        end
        btn = '0;
    endtask

    initial begin
        bus.Bus2IP_Data = '0;
        bus.Bus2IP_BE   = '0;
        bus.Bus2IP_RdCE = '0;
        bus.Bus2IP_WrCE = '0;
        test_reset();
        test_debounce();
        test_bounce();
        test_edge();
        test_w1c();
        test_be_err();
        test_gie();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
